// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the instruction-fetch slice.
//   XLEN / IMEM_ADDR_W / IMEM_BYTES - machine width and instruction-memory geometry
//   fetch_state_t                   - fetch FSM encoding (RUN, STALL, FAULT)
//   fetch_entry_t                   - prefetch FIFO entry {pc, inst}
//   pc_illegal()                    - true when a byte PC cannot be fetched from imem
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_BYTES  = 1024;
  localparam int IMEM_OFF_W  = $clog2(IMEM_BYTES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // A PC is fetchable only if it is word-aligned and inside the 1 KiB imem.
  function automatic logic pc_illegal(input logic [XLEN-1:0] pc);
    return (pc[XLEN-1:IMEM_OFF_W] != '0) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the imem, redirect/halt, decode handshake and fault
// signals of fetch_ctrl.
//   master - the fetch controller side (drives imem address, head entry, fault)
//   slave  - the environment side (imem data, redirect, halt, decode ready)
interface fetch_ctrl_if;
  import riscv_pkg::*;

  logic [IMEM_ADDR_W-1:0] imem_addr_o;
  logic [XLEN-1:0]        imem_data_i;
  logic                   redirect_i;
  logic [XLEN-1:0]        redirect_pc_i;
  logic                   halt_i;
  logic                   inst_valid_o;
  logic                   inst_ready_i;
  logic [XLEN-1:0]        inst_o;
  logic [XLEN-1:0]        inst_pc_o;
  logic                   fault_o;
  logic [XLEN-1:0]        fault_pc_o;

  modport master (
    output imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fault_o, fault_pc_o,
    input  imem_data_i, redirect_i, redirect_pc_i, halt_i, inst_ready_i
  );

  modport slave (
    input  imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fault_o, fault_pc_o,
    output imem_data_i, redirect_i, redirect_pc_i, halt_i, inst_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous prefetch FIFO of fetch_entry_t.
//   clk_i, rst_i  - clock, async active-high reset (storage cleared to zero)
//   flush_i       - synchronous flush, wins over push
//   push_i/data   - write one entry (ignored when full and not popping)
//   pop_i         - consume the head (ignored when empty)
//   head_valid_o  - FIFO not empty
//   head_o        - head entry, read straight out of the storage registers
//   count_o       - occupancy 0..DEPTH
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  output logic               head_valid_o,
  output fetch_entry_t       head_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic [CNT_W-1:0] count;
  logic             pop_eff, push_eff;

  // Wrap explicitly so non-power-of-two depths stay modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_eff  = pop_i & (count != '0);
  // Full + pop frees the slot the push lands in (wptr == rptr when full).
  assign push_eff = push_i & ((count < CNT_W'(DEPTH)) | pop_eff);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) begin
        mem[wptr] <= push_data_i;
        wptr      <= ptr_inc(wptr);
      end
      if (pop_eff) rptr <= ptr_inc(rptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid_o = (count != '0);
  assign head_o       = mem[rptr];
  assign count_o      = count;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
// Owns the fetch PC, addresses the asynchronous 256-word imem, pushes
// {pc, inst} into a prefetch FIFO and hands entries to decode over a
// valid/ready handshake. Redirects flush the FIFO; an unfetchable PC raises a
// sticky fault that only a redirect or reset clears.
//   clk_i, rst_i  - clock, async active-high reset
//   bus (master)  - imem_addr_o/imem_data_i, redirect_i/redirect_pc_i, halt_i,
//                   inst_valid_o/inst_ready_i/inst_o/inst_pc_o, fault_o/fault_pc_o
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state, state_nxt;
  logic [XLEN-1:0]  pc_r;
  logic             fault_r;
  logic [XLEN-1:0]  fault_pc_r;

  logic             deq, room, attempt, illegal;
  logic             push, fault_set;
  logic             head_valid;
  fetch_entry_t     head, push_data;
  logic [CNT_W-1:0] count;

  // A slot is available if the FIFO has space or the head leaves this cycle,
  // which keeps full-rate streaming with decode always ready.
  assign deq     = head_valid & bus.inst_ready_i;
  assign room    = (count < CNT_W'(FIFO_DEPTH)) | deq;
  assign attempt = (state == RUN) & room & ~bus.redirect_i;
  assign illegal = pc_illegal(pc_r);

  // ---- state register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  // ---- next-state logic ----
  // The fault check outranks halt: a RUN-state attempt at a bad PC faults
  // even if halt_i rises in the same cycle.
  always_comb begin
    state_nxt = state;
    if (bus.redirect_i) begin
      state_nxt = bus.halt_i ? STALL : RUN;
    end else begin
      case (state)
        RUN: begin
          if (attempt && illegal) state_nxt = FAULT;
          else if (bus.halt_i)    state_nxt = STALL;
          else                    state_nxt = RUN;
        end
        STALL:   state_nxt = bus.halt_i ? STALL : RUN;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RUN;
      endcase
    end
  end

  // ---- output / action logic ----
  always_comb begin
    push      = 1'b0;
    fault_set = 1'b0;
    if (attempt) begin
      if (illegal)           fault_set = 1'b1;
      else if (!bus.halt_i)  push      = 1'b1;
    end
  end

  // ---- PC and fault registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r       <= RESET_PC;
      fault_r    <= 1'b0;
      fault_pc_r <= '0;
    end else begin
      if (bus.redirect_i) pc_r <= bus.redirect_pc_i;
      else if (push)      pc_r <= pc_r + 32'd4;

      if (bus.redirect_i) fault_r <= 1'b0;
      else if (fault_set) fault_r <= 1'b1;

      // fault_pc keeps the last offender until the next fault or reset.
      if (fault_set) fault_pc_r <= pc_r;
    end
  end

  assign push_data.pc   = pc_r;
  assign push_data.inst = bus.imem_data_i;

  // A redirect in the same cycle as a dequeue: decode has taken the head,
  // and the flush then discards everything left behind it.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (bus.redirect_i),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (deq),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (count)
  );

  assign bus.imem_addr_o  = pc_r[IMEM_ADDR_W+1:2];
  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = head.inst;
  assign bus.inst_pc_o    = head.pc;
  assign bus.fault_o      = fault_r;
  assign bus.fault_pc_o   = fault_pc_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios, then a randomized run scored against a
// stream-level model: every accepted entry must be the next word of the
// current segment (reset PC or last redirect target), and a fault must name
// the first unfetchable PC of that segment.
module tb_fetch_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  assign bus.imem_data_i = mem[bus.imem_addr_o];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] p);
    return (p < 32'h400) && (p[1:0] == 2'b00);
  endfunction

  // Sequential fetch from a legal start runs off the end of imem at 0x400.
  function automatic logic [31:0] first_bad(input logic [31:0] start);
    return legal(start) ? 32'h400 : start;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; #2; rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        mon_en = 1'b0;
  logic [31:0] seg_q [$];
  logic [31:0] seg_start, exp_pc;
  logic        prev_fault, prev_redir;
  int          n_acc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.inst_valid_o && bus.inst_ready_i) begin
        n_acc++;
        chk("stream_pc", bus.inst_pc_o, exp_pc);
        chk("stream_inst", bus.inst_o, mem[exp_pc[9:2]]);
        chk("stream_legal", 32'(legal(bus.inst_pc_o)), 32'd1);
        exp_pc = exp_pc + 32'd4;
      end
      if (prev_redir) chk("fault_clr_after_redirect", 32'(bus.fault_o), 32'd0);
      if (bus.fault_o && !prev_fault) chk("fault_pc_random", bus.fault_pc_o, first_bad(seg_start));
      if (bus.redirect_i) begin
        if (seg_q.size() == 0) chk("seg_queue_nonempty", 32'd0, 32'd1);
        else begin
          seg_start = seg_q.pop_front();
          exp_pc    = seg_start;
        end
      end
      prev_fault = bus.fault_o;
      prev_redir = bus.redirect_i;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w [4];
    logic [31:0] t;
    w = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = w[i];

    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.halt_i        = 1'b0;
    bus.inst_ready_i  = 1'b1;

    // Reset values
    #1;
    chk("rst_valid",    32'(bus.inst_valid_o), 32'd0);
    chk("rst_inst",     bus.inst_o, 32'd0);
    chk("rst_inst_pc",  bus.inst_pc_o, 32'd0);
    chk("rst_fault",    32'(bus.fault_o), 32'd0);
    chk("rst_fault_pc", bus.fault_pc_o, 32'd0);
    chk("rst_addr",     32'(bus.imem_addr_o), 32'd0);

    // Streaming with ready high: first valid one edge after release
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream0_valid", 32'(bus.inst_valid_o), 32'd1);
      chk("stream0_pc",    bus.inst_pc_o, 32'(k * 4));
      chk("stream0_inst",  bus.inst_o, w[k]);
    end

    // Backpressure: FIFO holds PC 0 and 4, PC sits at word 2
    bus.inst_ready_i = 1'b0;
    pulse_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("bp_valid", 32'(bus.inst_valid_o), 32'd1);
    chk("bp_head",  bus.inst_pc_o, 32'd0);
    chk("bp_addr",  32'(bus.imem_addr_o), 32'd2);
    bus.inst_ready_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("bp_drain_pc", bus.inst_pc_o, 32'(k * 4));
    end

    // Redirect while full: head PC 0 taken, then 0x40 two edges later
    bus.inst_ready_i = 1'b0;
    pulse_reset();
    for (int k = 0; k < 3; k++) tick();
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h40;
    chk("rd_head_before", bus.inst_pc_o, 32'd0);
    tick();
    bus.redirect_i = 1'b0;
    chk("rd_no_stale", 32'(bus.inst_valid_o), 32'd0);
    tick();
    chk("rd_valid",  32'(bus.inst_valid_o), 32'd1);
    chk("rd_pc",     bus.inst_pc_o, 32'h40);
    chk("rd_inst",   bus.inst_o, mem[16]);

    // Misaligned redirect faults one cycle later; a good redirect recovers
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h42;
    tick();
    bus.redirect_i = 1'b0;
    chk("mis_fault_early", 32'(bus.fault_o), 32'd0);
    tick();
    chk("mis_fault",    32'(bus.fault_o), 32'd1);
    chk("mis_fault_pc", bus.fault_pc_o, 32'h42);
    chk("mis_no_push",  32'(bus.inst_valid_o), 32'd0);
    tick();
    chk("mis_pc_hold", 32'(bus.imem_addr_o), 32'h10);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h80;
    tick();
    bus.redirect_i = 1'b0;
    chk("rec_fault_clr", 32'(bus.fault_o), 32'd0);
    tick();
    chk("rec_pc", bus.inst_pc_o, 32'h80);

    // End of imem: 0x3FC delivered, 0x400 faults
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h3F8;
    tick();
    bus.redirect_i = 1'b0;
    tick();
    chk("end_pc_3f8", bus.inst_pc_o, 32'h3F8);
    tick();
    chk("end_pc_3fc", bus.inst_pc_o, 32'h3FC);
    chk("end_no_fault_yet", 32'(bus.fault_o), 32'd0);
    tick();
    chk("end_valid",    32'(bus.inst_valid_o), 32'd0);
    chk("end_fault",    32'(bus.fault_o), 32'd1);
    chk("end_fault_pc", bus.fault_pc_o, 32'h400);

    // Halt, then asynchronous reset mid-stream
    bus.halt_i = 1'b1;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
    tick();
    bus.redirect_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_no_push", 32'(bus.inst_valid_o), 32'd0);
      chk("halt_addr",    32'(bus.imem_addr_o), 32'h40);
    end
    bus.halt_i = 1'b0;
    tick();
    chk("unhalt_gap", 32'(bus.inst_valid_o), 32'd0);
    tick();
    chk("unhalt_pc", bus.inst_pc_o, 32'h100);
    tick();
    chk("unhalt_pc2", bus.inst_pc_o, 32'h104);
    #2 rst = 1'b1;
    #1;
    chk("async_valid",    32'(bus.inst_valid_o), 32'd0);
    chk("async_addr",     32'(bus.imem_addr_o), 32'd0);
    chk("async_fault_pc", bus.fault_pc_o, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("restart_pc", bus.inst_pc_o, 32'd0);

    // Randomized run against the stream model
    pulse_reset();
    seg_start  = 32'h0;
    exp_pc     = 32'h0;
    prev_fault = 1'b0;
    prev_redir = 1'b0;
    mon_en     = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.inst_ready_i = ($urandom_range(3) != 0);
      bus.halt_i       = ($urandom_range(9) == 0);
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(7))
          5:       t = 32'h3E0 + (32'($urandom_range(7)) << 2);
          6:       t = (32'($urandom_range(255)) << 2) | 32'($urandom_range(3, 1));
          7:       t = ($urandom() | 32'h400) & 32'hFFFF_FFFC;
          default: t = 32'($urandom_range(255)) << 2;
        endcase
        seg_q.push_back(t);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = t;
      end else begin
        bus.redirect_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    mon_en = 1'b0;
    chk("random_progress", 32'(n_acc > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
